gelato_icache_arbiter: RTL
==========================

# gelato_icache_arbiter

Round-robin arbiter that shares one L1 instruction-cache port between `NUM_REQ` instruction-fetch requesters, such as per-warp-group fetch units. Each requester-side port has the same valid/addr/ready/data semantics as the I-Fetch-to-I-Cache link. The arbiter sits between the fetch units and the I-Cache slave and acts as the single master of that link. It holds one transaction in flight at a time and latches the address. A per-requester flush lets a fetch unit abandon its pending response.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; must be at least 1.
- `ADDR_WIDTH`, default 32: width of `addr_t`.
- `DATA_WIDTH`, default 32: width of `data_t`.

Ports:
- `clk`  in  1  single clock; every register is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester fetch request; held high until that requester's `req_ready`.
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  fetch addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_flush`  in  NUM_REQ  requester i abandons its request or in-flight response.
- `req_ready`  out  NUM_REQ  one-cycle response strobe to the granted requester.
- `req_data`  out  DATA_WIDTH  response data, broadcast to all requesters; meaningful only with `req_ready`.
- `ic_valid`  out  1  request to the I-Cache.
- `ic_addr`  out  ADDR_WIDTH  latched request address.
- `ic_ready`  in  1  I-Cache response strobe.
- `ic_data`  in  DATA_WIDTH  I-Cache response data.
- `busy`  out  1  high while a transaction is outstanding (state BUSY).

## Operation
Registers:
- `state` ∈ {IDLE, BUSY}.
- `grant_idx` of width max(1, $clog2(NUM_REQ)).
- `rr_ptr` of the same width.
- `addr_q`.
- `drop_q`.

State machine:
- **IDLE, selection.** Compute `eligible = req_valid & ~req_flush`. Search the eligible requesters starting at `rr_ptr` and wrapping modulo NUM_REQ. The first match is the winner.
- **IDLE to BUSY.** If any requester is eligible, go to BUSY on the next edge with `grant_idx` = winner, `addr_q` = that requester's address, and `drop_q` = 0. Otherwise stay in IDLE.
- **BUSY, request.** `ic_valid` = 1 and `ic_addr` = `addr_q`. Both stay stable until `ic_ready` is high.
- **BUSY, flush.** If `req_flush[grant_idx]` is high in any BUSY cycle, including the `ic_ready` cycle, set `drop_q` (sticky). The cache request is never withdrawn.
- **BUSY, response.** In the cycle `ic_ready` = 1:
  - `req_ready[grant_idx]` = ~drop_eff, where drop_eff = `drop_q` | `req_flush[grant_idx]`. All other bits of `req_ready` are 0.
  - `req_data` = `ic_data`, driven combinationally.
  - Next state is IDLE, with `rr_ptr` = (`grant_idx` + 1) mod NUM_REQ.
- **Data when idle.** `req_data` is 0 whenever `ic_ready` is low.

Properties:
- `req_ready` is one-hot or zero at all times.
- Round-robin order guarantees no requester waits more than NUM_REQ−1 transactions.

## Timing
Reset values, applied asynchronously while `rst_n` = 0:
- `state` = IDLE, `rr_ptr` = 0, `grant_idx` = 0, `addr_q` = 0, `drop_q` = 0.
- Outputs: `ic_valid` = 0, `ic_addr` = 0, `req_ready` = 0, `busy` = 0.

Latency:
- Request sampled in IDLE at edge t: `ic_valid` is high from cycle t+1.
- A zero-wait cache (`ic_ready` high in cycle t+1) delivers `req_ready` in cycle t+1, then the arbiter is in IDLE at t+2.
- Best-case throughput is one transaction every 2 cycles, because of the single IDLE bubble.

Combinational vs registered:
- `ic_valid`, `ic_addr` and `busy` come directly from registers, with no combinational path from the `req_*` inputs.
- `req_ready` and `req_data` are combinational from `ic_ready`/`ic_data`.

Boundary conditions:
- A requester that drops `req_valid` in BUSY without flushing still receives its response.
- Flush of a non-granted requester in BUSY has no effect on the current transaction.
- When NUM_REQ = 1, `rr_ptr` stays 0.
- `rr_ptr` wraps from NUM_REQ−1 back to 0.
- Reset asserted mid-BUSY: the transaction is abandoned and `ic_valid` drops immediately.
- `ic_ready` while in IDLE is ignored and produces no `req_ready`.

## Test plan
- **Single request.** Reset, then `req_valid` = 4'b0100 with addr 0x1000; cache raises `ic_ready` 3 cycles after `ic_valid`, with data 0xDEADBEEF.
  - `ic_addr` = 0x1000 and `ic_valid` is high from the cycle after the request.
  - `req_ready` = 4'b0100 with `req_data` = 0xDEADBEEF; `rr_ptr` becomes 3.
- **Fairness.** All four requesters held valid with a zero-wait cache.
  - Grant order is 0,1,2,3,0.
  - `req_ready` pulses every 2 cycles.
- **Flush mid-flight.** Grant requester 1, assert `req_flush[1]` for one cycle before `ic_ready`.
  - `ic_valid` stays high until `ic_ready`.
  - `req_ready` stays 0 and the arbiter returns to IDLE.
- **Flush in IDLE.** `req_valid` = 4'b0011 with `req_flush` = 4'b0001 and `rr_ptr` = 0.
  - Requester 1 is granted.
- **Reset mid-BUSY.** Pull `rst_n` low while BUSY.
  - `ic_valid`, `busy` and `req_ready` are 0 immediately.
  - After release, `rr_ptr` = 0 and the first grant goes to the lowest eligible requester.
- **Spurious ready.** Pulse `ic_ready` while in IDLE with no requests.
  - `req_ready` stays 0 and the state stays IDLE.

Source files
------------

// File: rtl/gelato_icache_arbiter.sv
// Round-robin arbiter sharing one I-Cache port among NUM_REQ fetch requesters.
// One transaction in flight; per-requester flush suppresses the pending response.
module gelato_icache_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ-1:0]            req_flush,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         req_data,
    output logic                          ic_valid,
    output logic [ADDR_WIDTH-1:0]         ic_addr,
    input  logic                          ic_ready,
    input  logic [DATA_WIDTH-1:0]         ic_data,
    output logic                          busy
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t                  r_state;
    logic [IDX_W-1:0]        r_grant_idx;
    logic [IDX_W-1:0]        r_rr_ptr;
    logic [ADDR_WIDTH-1:0]   r_addr_q;
    logic                    r_drop_q;

    logic [NUM_REQ-1:0]      w_eligible;
    logic                    w_found;
    logic [IDX_W-1:0]        w_winner;
    logic [ADDR_WIDTH-1:0]   w_win_addr;
    logic                    w_flush_grant;
    logic                    w_drop_eff;
    logic [IDX_W-1:0]        w_next_ptr;

    assign w_eligible = req_valid & ~req_flush;

    // First eligible requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int unsigned v_idx;
        v_idx      = 0;
        w_found    = 1'b0;
        w_winner   = '0;
        w_win_addr = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            v_idx = (32'(r_rr_ptr) + k) % NUM_REQ;
            if (!w_found && w_eligible[v_idx]) begin
                w_found    = 1'b1;
                w_winner   = IDX_W'(v_idx);
                w_win_addr = req_addr[v_idx*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign w_flush_grant = req_flush[r_grant_idx];
    assign w_drop_eff    = r_drop_q | w_flush_grant;
    assign w_next_ptr    = (r_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant_idx + IDX_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_grant_idx <= '0;
            r_rr_ptr    <= '0;
            r_addr_q    <= '0;
            r_drop_q    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state     <= S_BUSY;
                        r_grant_idx <= w_winner;
                        r_addr_q    <= w_win_addr;
                        r_drop_q    <= 1'b0;
                    end
                end
                S_BUSY: begin
                    // Sticky: the cache request completes, only the response is discarded.
                    if (w_flush_grant) begin
                        r_drop_q <= 1'b1;
                    end
                    if (ic_ready) begin
                        r_state  <= S_IDLE;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ic_valid = (r_state == S_BUSY);
    assign busy     = (r_state == S_BUSY);
    assign ic_addr  = r_addr_q;

    always_comb begin
        req_ready = '0;
        if ((r_state == S_BUSY) && ic_ready) begin
            req_ready[r_grant_idx] = ~w_drop_eff;
        end
    end

    assign req_data = ic_ready ? ic_data : '0;

endmodule
